// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants, address type and width helpers
// for the integer register file with busy scoreboard.
package rf_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int DEPTH_DEF = 32;
  localparam int NREAD_DEF = 2;

  typedef logic [4:0] rf_addr_t;

  function automatic int rf_aw(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int rf_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback/issue bundle between the pipeline
// and the register file scoreboard.
interface regfile_scoreboard_if
  import rf_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int NREAD = NREAD_DEF
);

  localparam int AW = rf_aw(DEPTH);
  localparam int CW = rf_cw(DEPTH);

  logic [NREAD*AW-1:0]   rd_addr;
  logic [NREAD*XLEN-1:0] rd_data;
  logic [NREAD-1:0]      rd_busy;
  logic                  wb_en;
  logic [AW-1:0]         wb_addr;
  logic [XLEN-1:0]       wb_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_addr;
  logic                  flush;
  logic [CW-1:0]         pend_cnt;

  modport master (
    output rd_addr,
    output wb_en,
    output wb_addr,
    output wb_data,
    output iss_en,
    output iss_addr,
    output flush,
    input  rd_data,
    input  rd_busy,
    input  pend_cnt
  );

  modport slave (
    input  rd_addr,
    input  wb_en,
    input  wb_addr,
    input  wb_data,
    input  iss_en,
    input  iss_addr,
    input  flush,
    output rd_data,
    output rd_busy,
    output pend_cnt
  );

endinterface

// File: rtl/regfile_scoreboard_rf_read_port.sv
// One combinational read port: x0 forcing,
// writeback bypass and busy qualification.
module rf_read_port #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   addr,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] reg_data,
  input  logic            reg_busy,
  output logic [XLEN-1:0] data,
  output logic            busy
);

  logic zero;
  logic hit;
  logic fwd;

  assign zero = (addr == '0);
  assign hit  = wb_en && (wb_addr == addr);
  assign fwd  = (BYPASS != 0) && hit;

  always_comb begin
    data = reg_data;
    priority case (1'b1)
      zero:    data = '0;
      fwd:     data = wb_data;
      default: data = reg_data;
    endcase
  end

  // a completing producer is no longer a hazard
  assign busy = !zero && reg_busy && !hit;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with N read ports, one write port,
// writeback bypass and a per-register busy scoreboard.
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NREAD  = NREAD_DEF,
  parameter int BYPASS = 1
) (
  input logic               clk,
  input logic               rst,
  regfile_scoreboard_if.slave bus
);

  localparam int AW = rf_aw(DEPTH);
  localparam int CW = rf_cw(DEPTH);

  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [DEPTH-1:0] set_vec;
  logic [DEPTH-1:0] clr_vec;
  logic [CW-1:0]    pend_q;
  logic             wb_hit;
  logic             iss_hit;
  logic             inc;
  logic             dec;

  assign wb_hit  = bus.wb_en && (bus.wb_addr != '0);
  assign iss_hit = bus.iss_en
                && (bus.iss_addr != '0)
                && !bus.flush;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_hit) set_vec[bus.iss_addr] = 1'b1;
    if (wb_hit)  clr_vec[bus.wb_addr]  = 1'b1;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      busy_nxt = set_vec | (busy & ~clr_vec);
    end
    busy_nxt[0] = 1'b0;
  end

  // count deltas; a same-register issue masks the wb clear
  always_comb begin
    inc = iss_hit && !busy[bus.iss_addr];
    dec = wb_hit && busy[bus.wb_addr]
       && !(iss_hit && (bus.iss_addr == bus.wb_addr));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= '0;
      pend_q <= '0;
      for (int r = 0; r < DEPTH; r++) begin
        regs[r] <= '0;
      end
    end else begin
      busy <= busy_nxt;
      if (bus.flush) begin
        pend_q <= '0;
      end else begin
        pend_q <= pend_q
                + {{(CW-1){1'b0}}, inc}
                - {{(CW-1){1'b0}}, dec};
      end
      if (wb_hit) begin
        regs[bus.wb_addr] <= bus.wb_data;
      end
    end
  end

  assign bus.pend_cnt = pend_q;

  logic [NREAD*XLEN-1:0] rdata_w;
  logic [NREAD-1:0]      rbusy_w;

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0] a;
    assign a = bus.rd_addr[p*AW +: AW];

    rf_read_port #(
      .XLEN   (XLEN),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rd (
      .addr     (a),
      .wb_en    (bus.wb_en),
      .wb_addr  (bus.wb_addr),
      .wb_data  (bus.wb_data),
      .reg_data (regs[a]),
      .reg_busy (busy[a]),
      .data     (rdata_w[p*XLEN +: XLEN]),
      .busy     (rbusy_w[p])
    );
  end

  assign bus.rd_data = rdata_w;
  assign bus.rd_busy = rbusy_w;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Random + directed bench for regfile_scoreboard
// against an array-based reference model.
module tb_regfile_scoreboard;
  import rf_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_scoreboard_if #(
    .XLEN(32), .DEPTH(64), .NREAD(4)
  ) a_if ();

  regfile_scoreboard_if #(
    .XLEN(32), .DEPTH(32), .NREAD(2)
  ) b_if ();

  regfile_scoreboard #(
    .XLEN(32), .DEPTH(64), .NREAD(4), .BYPASS(1)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  regfile_scoreboard #(
    .XLEN(32), .DEPTH(32), .NREAD(2), .BYPASS(0)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_regs [64];
  bit          m_busy [64];
  int          ra [4];

  // reference: architectural state updated by the rules
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 64; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
    end else begin
      if (a_if.wb_en && a_if.wb_addr != 0)
        m_regs[a_if.wb_addr] = a_if.wb_data;
      if (a_if.flush) begin
        for (int r = 0; r < 64; r++) m_busy[r] = 1'b0;
      end else begin
        if (a_if.wb_en && a_if.wb_addr != 0)
          m_busy[a_if.wb_addr] = 1'b0;
        if (a_if.iss_en && a_if.iss_addr != 0)
          m_busy[a_if.iss_addr] = 1'b1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_ra();
    logic [5:0] a6;
    for (int p = 0; p < 4; p++) begin
      a6 = ra[p][5:0];
      a_if.rd_addr[p*6 +: 6] = a6;
    end
  endtask

  task automatic compare_all(input string tag);
    int          a;
    bit          hit;
    logic [31:0] ed;
    bit          eb;
    int          cnt;
    for (int p = 0; p < 4; p++) begin
      a   = ra[p];
      hit = a_if.wb_en && (a_if.wb_addr == a);
      ed  = (a == 0) ? 32'h0 :
            hit ? a_if.wb_data : m_regs[a];
      eb  = (a != 0) && m_busy[a] && !hit;
      check($sformatf("%s rd_data%0d", tag, p),
            64'(a_if.rd_data[p*32 +: 32]), 64'(ed));
      check($sformatf("%s rd_busy%0d", tag, p),
            64'(a_if.rd_busy[p]), 64'(eb));
    end
    cnt = 0;
    for (int r = 0; r < 64; r++) cnt += int'(m_busy[r]);
    check($sformatf("%s pend_cnt", tag),
          64'(a_if.pend_cnt), 64'(cnt));
  endtask

  task automatic drive(input bit we, input int wa,
                       input logic [31:0] wd,
                       input bit ie, input int ia,
                       input bit fl, input string tag);
    logic [5:0] w6;
    logic [5:0] i6;
    w6 = wa[5:0];
    i6 = ia[5:0];
    @(negedge clk);
    a_if.wb_en    = we;
    a_if.wb_addr  = w6;
    a_if.wb_data  = wd;
    a_if.iss_en   = ie;
    a_if.iss_addr = i6;
    a_if.flush    = fl;
    set_ra();
    #1;
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    drive(0, 0, 32'h0, 0, 0, 0, tag);
  endtask

  function automatic int pick(input int wa);
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return wa;
    if (k == 1) return $urandom_range(0, 7);
    return $urandom_range(0, 63);
  endfunction

  initial begin
    int wa;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    a_if.wb_en = 0; a_if.wb_addr = 0;
    a_if.wb_data = 0; a_if.iss_en = 0;
    a_if.iss_addr = 0; a_if.flush = 0;
    b_if.wb_en = 0; b_if.wb_addr = 0;
    b_if.wb_data = 0; b_if.iss_en = 0;
    b_if.iss_addr = 0; b_if.flush = 0;
    b_if.rd_addr = '0;
    for (int p = 0; p < 4; p++) ra[p] = p + 1;
    set_ra();
    #2;
    check("rst pend", 64'(a_if.pend_cnt), 64'd0);
    check("rst busy", 64'(a_if.rd_busy), 64'd0);
    check("rst data", 64'(a_if.rd_data[31:0]), 64'd0);
    check("rst b pend", 64'(b_if.pend_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // x0 writes and issues are ignored
    for (int p = 0; p < 4; p++) ra[p] = 0;
    drive(1, 0, 32'h1234, 1, 0, 0, "x0");
    check("x0 data", 64'(a_if.rd_data), 64'd0);
    idle("x0 idle");
    check("x0 busy", 64'(a_if.rd_busy), 64'd0);
    check("x0 pend", 64'(a_if.pend_cnt), 64'd0);

    // reissue with simultaneous writeback
    ra[0] = 7;
    drive(0, 0, 32'h0, 1, 7, 0, "iss7");
    drive(1, 7, 32'hA, 1, 7, 0, "iss7wb7");
    idle("iss7 idle");
    check("iss7 pend", 64'(a_if.pend_cnt), 64'd1);
    check("iss7 busy", 64'(a_if.rd_busy[0]), 64'd1);
    drive(1, 7, 32'hB, 0, 0, 0, "wb7");
    idle("wb7 idle");
    check("wb7 pend", 64'(a_if.pend_cnt), 64'd0);
    check("wb7 busy", 64'(a_if.rd_busy[0]), 64'd0);
    check("wb7 data", 64'(a_if.rd_data[31:0]), 64'hB);

    // flush beats issue; writeback still lands
    ra[0] = 1; ra[1] = 2; ra[2] = 3; ra[3] = 4;
    drive(0, 0, 32'h0, 1, 1, 0, "iss1");
    drive(0, 0, 32'h0, 1, 2, 0, "iss2");
    drive(0, 0, 32'h0, 1, 3, 0, "iss3");
    idle("iss3 idle");
    check("iss123 pend", 64'(a_if.pend_cnt), 64'd3);
    drive(1, 2, 32'h55, 1, 4, 1, "flush");
    idle("flush idle");
    check("flush pend", 64'(a_if.pend_cnt), 64'd0);
    check("flush busy", 64'(a_if.rd_busy), 64'd0);
    check("flush x2", 64'(a_if.rd_data[63:32]), 64'h55);

    // bypass vs. no bypass
    ra[0] = 5;
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, "byp");
    check("byp same", 64'(a_if.rd_data[31:0]),
          64'hDEADBEEF);
    idle("byp idle");
    @(negedge clk);
    b_if.rd_addr = {5'd0, 5'd5};
    b_if.wb_en = 1; b_if.wb_addr = 5;
    b_if.wb_data = 32'h11;
    @(negedge clk);
    b_if.wb_data = 32'hDEADBEEF;
    #1;
    check("nobyp old", 64'(b_if.rd_data[31:0]), 64'h11);
    check("nobyp x0", 64'(b_if.rd_data[63:32]), 64'h0);
    @(negedge clk);
    b_if.wb_en = 0;
    #1;
    check("nobyp new", 64'(b_if.rd_data[31:0]),
          64'hDEADBEEF);

    // randomized traffic
    for (int c = 0; c < 10000; c++) begin
      wa = pick(0);
      for (int p = 0; p < 4; p++) ra[p] = pick(wa);
      drive($urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 1) == 1, pick(wa),
            $urandom_range(0, 31) == 0, "rnd");
    end

    // asynchronous reset mid-run
    ra[0] = 9;
    drive(1, 9, 32'hCAFE0009, 1, 9, 0, "pre");
    drive(0, 0, 32'h0, 1, 10, 0, "pre2");
    idle("pre idle");
    check("pre data", 64'(a_if.rd_data[31:0]),
          64'hCAFE0009);
    check("pre busy", 64'(a_if.rd_busy[0]), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst data", 64'(a_if.rd_data), 64'd0);
    check("arst busy", 64'(a_if.rd_busy), 64'd0);
    check("arst pend", 64'(a_if.pend_cnt), 64'd0);
    check("arst b data", 64'(b_if.rd_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle("post rst");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
